output4to1: RTL
===============

Name: output4to1

Overview:
- Router output port: the merge end of the 1-to-4 input demux. It collects packets from four input-port demux branches and arbitrates them round-robin onto one outgoing link.
- Every port uses a 4-phase req/ack handshake with bundled data.
- Clocked block. It is the synchronous counterpart of the asynchronous input stage, and it can face click-based neighbours when the optional synchronizer feature is enabled.

Parameters:
- n, 8, flit width in bits (destination x/y fields in the MSBs; the block passes them through untouched).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- in_req  input  4  request per source; index i matches demux output outs[i].
- in_ack  output  4  acknowledge per source.
- in_data  input  4 x n  data per source; stable while in_req[i]=1.
- out_req  output  1  outgoing link request.
- out_ack  input  1  outgoing link acknowledge.
- out_data  output  n  outgoing flit, registered.
- grant  output  2  index of the source currently being served; holds the last value when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - in_ack=0, out_req=0, out_data=0, grant=0, busy=0.
  - state=IDLE; round-robin pointer last=3, so port 0 has first priority.
- Handshake on every port (4-phase):
  - Sender raises req with data stable.
  - Receiver raises ack.
  - Sender drops req.
  - Receiver drops ack.
  - The block never drops out_req before out_ack=1, and never raises out_req while out_ack=1.
- FSM states: IDLE, SEND, RELEASE.
- IDLE:
  - If any in_req (synchronized value) is 1, pick winner w = the first requesting index after last, searched modulo 4.
  - At the clock edge: out_data<=in_data[w], grant<=w, out_req<=1, state<=SEND.
  - Latency is one clock from req seen to out_req=1.
  - If no requests, stay in IDLE.
- SEND:
  - Wait for out_ack=1, then: out_req<=0, in_ack[w]<=1, state<=RELEASE.
  - out_data holds constant throughout SEND.
- RELEASE:
  - Wait for out_ack=0 AND in_req[w]=0, then: in_ack[w]<=0, last<=w, state<=IDLE.
  - The two conditions may arrive in either order or in the same cycle.
- Only in_ack[w] is ever asserted; at most one in_ack bit is high at any time.
- Simultaneous requests: exactly one winner per transaction; the others wait with their req held. No request is starved; worst-case wait is 3 transactions.
- A request that arrives during SEND or RELEASE is not sampled until the next IDLE.
- A new transaction can start in the cycle after RELEASE exits. Minimum transaction length is 3 clocks plus peer response time.
- Requests are never dropped while pending. The block assumes in_req[i] does not fall before in_ack[i]; a violation is a protocol error with undefined result.
- Reset mid-transaction clears everything asynchronously. Peers must also be reset.

Optional Feature:
- Macro: OUTPUT4TO1_REQ_SYNC_EN.
- Defined:
  - in_req[3:0] and out_ack each pass through a 2-flop synchronizer; the flops reset to 0.
  - The FSM reacts to synchronized values only, adding 2 clocks of latency on each incoming edge.
  - in_data is still sampled directly: bundled data is stable once req has been synchronized.
- Undefined: inputs go straight into the FSM; all inputs are assumed synchronous to clk.

Test Plan:
- Single flit: in_req[2]=1, in_data[2]=8'hA5 -> next clock out_req=1, out_data=8'hA5, grant=2. Then out_ack=1 -> out_req=0, in_ack[2]=1. Then drop in_req[2] and out_ack -> in_ack[2]=0, busy=0.
- Fairness after reset: all four req held high with data 8'h10,8'h21,8'h32,8'h43 -> grants 0,1,2,3 in order, out_data in matching order, then 0 again if the reqs are re-raised.
- Round-robin wrap: last=3, then in_req[3] and in_req[1] high -> port 1 wins first, then port 3.
- Release ordering: in RELEASE, drop in_req[w] 3 clocks before out_ack falls, and in a second run 3 clocks after -> in_ack[w] falls only after both are low; no out_req during the wait.
- Reset mid-SEND: assert rst=0 while out_req=1 -> out_req, in_ack, out_data, grant go to 0 immediately without waiting for a clock; after release, port 0 has priority.
- With OUTPUT4TO1_REQ_SYNC_EN: single flit -> out_req rises 3 clocks after in_req (vs 1), and in_ack rises 3 clocks after out_ack (vs 1).

Source files
------------

// File: rtl/output4to1_if.sv
// Bundled-data req/ack bus for the output4to1 router output port.
// Parameter: n - flit width in bits.
// Signals:
//   in_req/in_ack/in_data    - four input-side 4-phase channels, index i per source
//   out_req/out_ack/out_data - single outgoing 4-phase link
// Modports: master = router output port view, slave = environment view.
interface output4to1_if #(
  parameter int unsigned n = 8
);
  logic [3:0]          in_req;
  logic [3:0]          in_ack;
  logic [3:0][n-1:0]   in_data;
  logic                out_req;
  logic                out_ack;
  logic [n-1:0]        out_data;

  modport master (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data
  );

  modport slave (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data
  );
endinterface

// File: rtl/output4to1.sv
// Router output port: merges four 4-phase req/ack input channels onto one
// outgoing link with round-robin arbitration.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset
//   bus   - output4to1_if.master (in_req/in_ack/in_data, out_req/out_ack/out_data)
//   grant - index of the source being served, holds last value when idle
//   busy  - high whenever the FSM is not in IDLE
// Option: define OUTPUT4TO1_REQ_SYNC_EN to pass in_req and out_ack through
// 2-flop synchronizers before the FSM (in_data stays unsynchronized).
module output4to1 #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst,
  output4to1_if.master bus,
  output logic [1:0]   grant,
  output logic         busy
);

  localparam int unsigned PORTS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PORTS-1:0]   in_ack_q, in_ack_d;
  logic               out_req_q, out_req_d;
  logic [n-1:0]       out_data_q, out_data_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_q, last_d;
  logic               busy_q, busy_d;

  logic [PORTS-1:0]   req_s;
  logic               ack_s;
  logic               win_valid;
  logic [1:0]         win_idx;
  logic [1:0]         cand;

`ifdef OUTPUT4TO1_REQ_SYNC_EN
  logic [PORTS-1:0]   req_meta_q, req_sync_q;
  logic               ack_meta_q, ack_sync_q;

  // Two-flop synchronizers for the incoming handshake edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      req_meta_q <= bus.in_req;
      req_sync_q <= req_meta_q;
      ack_meta_q <= bus.out_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign req_s = req_sync_q;
  assign ack_s = ack_sync_q;
`else
  assign req_s = bus.in_req;
  assign ack_s = bus.out_ack;
`endif

  // Round-robin pick: first requester after last_q, modulo 4. Scanning from the
  // farthest offset down lets the nearest requester overwrite earlier hits.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = int'(PORTS); k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req_s[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    in_ack_d   = in_ack_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    grant_d    = grant_q;
    last_d     = last_q;

    case (state_q)
      IDLE: begin
        // out_ack must be low before a new out_req may rise
        if (win_valid && !ack_s) begin
          out_data_d = bus.in_data[win_idx];
          grant_d    = win_idx;
          out_req_d  = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (ack_s) begin
          out_req_d = 1'b0;
          in_ack_d  = PORTS'(4'b0001 << grant_q);
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        // Both the link ack and the source req must be low, in either order
        if (!ack_s && !req_s[grant_q]) begin
          in_ack_d = '0;
          last_d   = grant_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        in_ack_d  = '0;
        out_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_ack_q   <= '0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      grant_q    <= 2'd0;
      last_q     <= 2'd3;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ack_q   <= in_ack_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ack   = in_ack_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
  assign grant        = grant_q;
  assign busy         = busy_q;

endmodule
